// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types and constants for the codec sample feeder
package feeder_pkg;

  typedef enum logic [1:0] {PRIME, RUN, GUARD} feeder_state_t;

  typedef logic signed [15:0] sample_t;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/codec_sample_feeder_if.sv
// rtl/codec_sample_feeder_if.sv - codec write-port handshake between feeder and audio codec
interface codec_sample_feeder_if #(
  parameter int DATA_W = 16
);

  logic              write_ready;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    input  write_ready,
    output write,
    output writedata_left,
    output writedata_right
  );

  modport slave (
    output write_ready,
    input  write,
    input  writedata_left,
    input  writedata_right
  );

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - register-array sample FIFO with registered fill/flags and sticky overflow
module sample_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FILL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill,
  output logic              overflow
);

  localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [FILL_W-1:0] fill_nxt;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    fill_nxt = fill;
    if (push_ok && !pop_ok)
      fill_nxt = fill + 1'b1;
    else if (pop_ok && !push_ok)
      fill_nxt = fill - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      fill  <= fill_nxt;
      full  <= (fill_nxt == DEPTH_F);
      empty <= (fill_nxt == '0);
      if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/codec_sample_feeder.sv
// rtl/codec_sample_feeder.sv - elastic sample stage between flash playback and the audio codec write port
module codec_sample_feeder
  import feeder_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int DEPTH     = 16,
  parameter  int PRIME_LVL = 8,
  localparam int FILL_W    = $clog2(DEPTH) + 1
) (
  input  logic                     CLK_50M,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        sample_in,
  input  logic                     sample_valid,
  input  logic                     mute,
  input  logic [2:0]               vol_shift,
  codec_sample_feeder_if.master    codec,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [FILL_W-1:0]        fill_level,
  output logic [15:0]              underrun_count,
  output logic                     overflow
);

  localparam logic [FILL_W-1:0] PRIME_FILL = FILL_W'(PRIME_LVL);

  feeder_state_t            state;
  logic                     pop;
  logic [DATA_W-1:0]        pop_data;
  logic signed [DATA_W-1:0] scaled;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (CLK_50M),
    .reset_n   (reset_n),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill_level),
    .overflow  (overflow)
  );

  assign pop    = (state == RUN) && codec.write_ready && !fifo_empty;
  assign scaled = $signed(pop_data) >>> vol_shift;

  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      state                 <= PRIME;
      codec.write           <= 1'b0;
      codec.writedata_left  <= '0;
      codec.writedata_right <= '0;
      underrun_count        <= '0;
    end else begin
      codec.write <= 1'b0;
      case (state)
        PRIME: begin
          if (fill_level >= PRIME_FILL)
            state <= RUN;
        end
        RUN: begin
          if (codec.write_ready) begin
            if (!fifo_empty) begin
              codec.write           <= 1'b1;
              codec.writedata_left  <= mute ? '0 : scaled;
              codec.writedata_right <= mute ? '0 : scaled;
              state                 <= GUARD;
            end else begin
              // Starved: rebuild the cushion before resuming playback.
              if (underrun_count != UNDERRUN_MAX)
                underrun_count <= underrun_count + 1'b1;
              state <= PRIME;
            end
          end
        end
        GUARD:   state <= RUN;
        default: state <= PRIME;
      endcase
    end
  end

endmodule
